sa3x3_drain: RTL and testbench

Output collector for the 3x3 weight-stationary systolic array. Takes the three column partial-sum outputs, which leave the bottom PE row skewed by one cycle per column, and deskews them into one aligned 3-element result row. Buffers rows in a small FIFO and presents them on a valid/ready stream with a frame-end marker. Sits between the array's bottom edge and the downstream result writer, which can stall even though the array cannot.

---
 rtl/sa3x3_drain.sv | 110 +++++++++++
 tb/tb_sa3x3_drain.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sa3x3_drain.sv
// Output collector for the 3x3 systolic array: deskews the three column psums into
// one aligned row, queues rows in a small FIFO and streams them with a frame-end marker.
module sa3x3_drain #(
  parameter int DW        = 8,
  parameter int DEPTH     = 4,
  parameter int FRAME_LEN = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     v_in,
  input  logic [DW-1:0]            psum_in1,
  input  logic [DW-1:0]            psum_in2,
  input  logic [DW-1:0]            psum_in3,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DW-1:0]            out_c1,
  output logic [DW-1:0]            out_c2,
  output logic [DW-1:0]            out_c3,
  output logic                     out_last,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int FW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  typedef struct packed {
    logic [DW-1:0] c1;
    logic [DW-1:0] c2;
    logic [DW-1:0] c3;
    logic          last;
  } row_t;

  row_t            mem [DEPTH];
  logic [CW-1:0]   wr_ptr;
  logic [CW-1:0]   rd_ptr;

  logic            tag0;
  logic            tag1;
  logic [DW-1:0]   s0_c1;
  logic [DW-1:0]   s1_c1;
  logic [DW-1:0]   s1_c2;
  logic [FW-1:0]   frm;

  logic            frm_last;
  logic            full;
  logic            pop;
  logic            push_ok;
  row_t            head;
  row_t            new_row;

  assign count     = wr_ptr - rd_ptr;
  assign out_valid = (count != '0);
  assign full      = (count == CW'(DEPTH));
  assign pop       = out_valid && out_ready;
  assign frm_last  = (frm == FW'(FRAME_LEN - 1));

  // Stage 2 of the deskew is the FIFO write itself: column 3 is taken straight
  // from the input in the cycle tag1 is high.
  assign push_ok   = tag1 && !clear && (!full || pop);
  assign new_row   = '{c1: s1_c1, c2: s1_c2, c3: psum_in3, last: frm_last};

  assign head      = mem[rd_ptr[AW-1:0]];
  assign out_c1    = out_valid ? head.c1   : '0;
  assign out_c2    = out_valid ? head.c2   : '0;
  assign out_c3    = out_valid ? head.c3   : '0;
  assign out_last  = out_valid ? head.last : 1'b0;

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= new_row;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag0     <= 1'b0;
      tag1     <= 1'b0;
      s0_c1    <= '0;
      s1_c1    <= '0;
      s1_c2    <= '0;
      frm      <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      tag0     <= 1'b0;
      tag1     <= 1'b0;
      frm      <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      tag0 <= v_in;
      if (v_in) s0_c1 <= psum_in1;
      tag1 <= tag0;
      if (tag0) begin
        s1_c1 <= s0_c1;
        s1_c2 <= psum_in2;
      end
      // Frame position advances on every push attempt, so a dropped row still
      // occupies its slot in the frame.
      if (tag1) frm <= frm_last ? '0 : frm + FW'(1);
      if (push_ok) wr_ptr <= wr_ptr + CW'(1);
      if (pop) rd_ptr <= rd_ptr + CW'(1);
      if (tag1 && full && !pop) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sa3x3_drain.sv
// Directed self-checking bench for sa3x3_drain with hand-computed expectations
// (DW=8, DEPTH=4, FRAME_LEN=3).
module tb_sa3x3_drain;

  logic       clk;
  logic       rst;
  logic       clear;
  logic       v_in;
  logic [7:0] psum_in1;
  logic [7:0] psum_in2;
  logic [7:0] psum_in3;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_c1;
  logic [7:0] out_c2;
  logic [7:0] out_c3;
  logic       out_last;
  logic [2:0] count;
  logic       overflow;

  int errors = 0;
  int checks = 0;

  sa3x3_drain #(.DW(8), .DEPTH(4), .FRAME_LEN(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .v_in      (v_in),
    .psum_in1  (psum_in1),
    .psum_in2  (psum_in2),
    .psum_in3  (psum_in3),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_c1    (out_c1),
    .out_c2    (out_c2),
    .out_c3    (out_c3),
    .out_last  (out_last),
    .count     (count),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] p1, input logic [7:0] p2,
                       input logic [7:0] p3);
    v_in     = v;
    psum_in1 = p1;
    psum_in2 = p2;
    psum_in3 = p3;
  endtask

  task automatic do_clear();
    drive(1'b0, 8'h00, 8'h00, 8'h00);
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    rst = 1'b0; clear = 1'b0; out_ready = 1'b0;
    drive(1'b0, 8'h00, 8'h00, 8'h00);
    #3;
    check("rst_valid", out_valid, 0);
    check("rst_count", count, 0);
    check("rst_ovf", overflow, 0);
    check("rst_c1", out_c1, 0);
    check("rst_last", out_last, 0);
    tick();
    rst = 1'b1;

    // single row
    out_ready = 1'b1;
    drive(1'b1, 8'h11, 8'h00, 8'h00); tick();
    drive(1'b0, 8'h00, 8'h22, 8'h00); tick();
    drive(1'b0, 8'h00, 8'h00, 8'h33);
    check("single_early_valid", out_valid, 0);
    tick();
    drive(1'b0, 8'h00, 8'h00, 8'h00);
    check("single_valid", out_valid, 1);
    check("single_c1", out_c1, 8'h11);
    check("single_c2", out_c2, 8'h22);
    check("single_c3", out_c3, 8'h33);
    check("single_last", out_last, 0);
    check("single_count", count, 1);
    tick();
    check("single_count_after", count, 0);
    check("single_valid_after", out_valid, 0);
    check("single_c1_zero", out_c1, 0);

    // back-to-back frame of 6 rows
    do_clear();
    check("clr_valid", out_valid, 0);
    for (int k = 0; k < 10; k++) begin
      drive(k < 6, 8'(k + 1), 8'(k + 'h10), 8'(k - 1 + 'h20));
      if (k >= 3 && k <= 8) begin
        check("b2b_valid", out_valid, 1);
        check("b2b_c1", out_c1, k - 2);
        check("b2b_c2", out_c2, k - 2 + 'h10);
        check("b2b_c3", out_c3, k - 2 + 'h20);
        check("b2b_last", out_last, ((k - 3) % 3) == 2);
      end else begin
        check("b2b_idle", out_valid, 0);
      end
      tick();
    end

    // backpressure and overflow
    do_clear();
    out_ready = 1'b0;
    for (int k = 0; k < 7; k++) begin
      drive(k < 5, 8'(k + 1), 8'(k + 'h10), 8'(k - 1 + 'h20));
      if (k == 6) begin
        check("bp_count_full", count, 4);
        check("bp_ovf_before", overflow, 0);
        check("bp_hold_c1", out_c1, 1);
      end
      tick();
    end
    drive(1'b0, 8'h00, 8'h00, 8'h00);
    check("bp_count", count, 4);
    check("bp_ovf", overflow, 1);
    check("bp_hold_c1b", out_c1, 1);
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("bp_drain_c1", out_c1, i);
      check("bp_drain_c3", out_c3, i + 'h20);
      check("bp_drain_last", out_last, i == 3);
      tick();
    end
    check("bp_empty", out_valid, 0);
    check("bp_ovf_sticky", overflow, 1);
    drive(1'b1, 8'h06, 8'h00, 8'h00); tick();
    drive(1'b0, 8'h00, 8'h16, 8'h00); tick();
    drive(1'b0, 8'h00, 8'h00, 8'h26); tick();
    drive(1'b0, 8'h00, 8'h00, 8'h00);
    check("bp_row6_c1", out_c1, 8'h06);
    check("bp_row6_c2", out_c2, 8'h16);
    check("bp_row6_c3", out_c3, 8'h26);
    check("bp_row6_last", out_last, 1);
    tick();

    // full with simultaneous pop
    do_clear();
    out_ready = 1'b0;
    for (int k = 0; k < 7; k++) begin
      drive(k < 5, 8'(k + 1), 8'(k + 'h10), 8'(k - 1 + 'h20));
      out_ready = (k == 6);
      if (k == 6) check("fp_count_full", count, 4);
      tick();
    end
    drive(1'b0, 8'h00, 8'h00, 8'h00);
    out_ready = 1'b0;
    check("fp_count", count, 4);
    check("fp_ovf", overflow, 0);
    check("fp_head", out_c1, 2);
    out_ready = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      check("fp_drain_c1", out_c1, i);
      check("fp_drain_last", out_last, i == 3);
      tick();
    end
    check("fp_empty", out_valid, 0);

    // clear mid-flight
    do_clear();
    out_ready = 1'b0;
    drive(1'b1, 8'h01, 8'h00, 8'h00); tick();
    drive(1'b1, 8'h02, 8'h11, 8'h00); tick();
    drive(1'b0, 8'h00, 8'h12, 8'h21); tick();
    drive(1'b0, 8'h00, 8'h00, 8'h22); tick();
    drive(1'b1, 8'h03, 8'h00, 8'h00);
    check("cm_count_pre", count, 2);
    tick();
    drive(1'b0, 8'h00, 8'h13, 8'h00);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    drive(1'b0, 8'h00, 8'h00, 8'h23);
    check("cm_count", count, 0);
    check("cm_valid", out_valid, 0);
    check("cm_c1", out_c1, 0);
    tick();
    check("cm_no_late_push", count, 0);
    out_ready = 1'b1;
    drive(1'b1, 8'h07, 8'h00, 8'h00); tick();
    drive(1'b0, 8'h00, 8'h17, 8'h00); tick();
    drive(1'b0, 8'h00, 8'h00, 8'h27); tick();
    drive(1'b0, 8'h00, 8'h00, 8'h00);
    check("cm_new_valid", out_valid, 1);
    check("cm_new_c1", out_c1, 8'h07);
    check("cm_new_c3", out_c3, 8'h27);
    check("cm_new_last", out_last, 0);
    tick();

    // async reset mid-stream
    do_clear();
    out_ready = 1'b0;
    drive(1'b1, 8'h08, 8'h00, 8'h00); tick();
    drive(1'b0, 8'h00, 8'h18, 8'h00); tick();
    drive(1'b0, 8'h00, 8'h00, 8'h28); tick();
    drive(1'b1, 8'haa, 8'h00, 8'h00);
    check("ar_count_pre", count, 1);
    check("ar_valid_pre", out_valid, 1);
    #3;
    rst = 1'b0;
    #1;
    check("ar_valid", out_valid, 0);
    check("ar_count", count, 0);
    check("ar_c1", out_c1, 0);
    check("ar_ovf", overflow, 0);
    drive(1'b0, 8'h00, 8'h00, 8'h00);
    #2;
    rst = 1'b1;
    tick();
    check("ar_after_count", count, 0);
    out_ready = 1'b1;
    drive(1'b1, 8'h09, 8'h00, 8'h00); tick();
    drive(1'b0, 8'h00, 8'h19, 8'h00); tick();
    drive(1'b0, 8'h00, 8'h00, 8'h29);
    check("ar_early_valid", out_valid, 0);
    tick();
    drive(1'b0, 8'h00, 8'h00, 8'h00);
    check("ar_new_valid", out_valid, 1);
    check("ar_new_c1", out_c1, 8'h09);
    check("ar_new_c2", out_c2, 8'h19);
    check("ar_new_c3", out_c3, 8'h29);
    check("ar_new_last", out_last, 0);
    tick();
    check("ar_drained", count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
